// File: rtl/brom_copier_pkg.sv
// Shared types and constants for the boot-ROM-to-RAM copier.
//   state_t    : copier FSM state encoding (2 bits)
//   BUS_W      : bus word width in bits
//   WORD_BYTES : byte stride between consecutive bus words
//   word_addr  : base + idx * WORD_BYTES, modulo 2^BUS_W
package brom_copier_pkg;

  localparam int unsigned BUS_W      = 32;
  localparam int unsigned WORD_BYTES = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } state_t;

  // Byte address of word idx above base; wraps silently at 2^BUS_W.
  function automatic logic [BUS_W-1:0] word_addr(input logic [BUS_W-1:0] base,
                                                 input logic [BUS_W-1:0] idx);
    return base + idx * BUS_W'(WORD_BYTES);
  endfunction

endpackage

// File: rtl/brom_copier.sv
// Boot-time copier: reads i_count consecutive 32-bit words from the boot ROM
// starting at SRC_BASE and writes them to RAM starting at DST_BASE, one word at
// a time (read, then write, then next read).
//
// Optional build macro: BROM_COPIER_CHECKSUM_EN adds o_checksum, the modulo
// 2^32 sum of every word read during the current/last copy.
//
// Ports:
//   i_clock, i_reset     clock; asynchronous active-high reset
//   i_start, i_count     start strobe (IDLE only) and word count latched on it
//   o_busy, o_done       copy in progress; one-cycle completion pulse
//   o_src_*/i_src_*      ROM request/ready read port
//   o_dst_*/i_dst_*      RAM request/ready write port (o_dst_rw=1 means write)
//   o_checksum           (macro only) running sum of words read
module brom_copier
  import brom_copier_pkg::*;
#(
  parameter logic [31:0] SRC_BASE = 32'h0000_0000,
  parameter logic [31:0] DST_BASE = 32'h0000_0000,
  parameter int unsigned COUNT_W  = 16
) (
  input  logic               i_clock,
  input  logic               i_reset,
  input  logic               i_start,
  input  logic [COUNT_W-1:0] i_count,
  output logic               o_busy,
  output logic               o_done,
  output logic               o_src_request,
  output logic [BUS_W-1:0]   o_src_address,
  input  logic [BUS_W-1:0]   i_src_rdata,
  input  logic               i_src_ready,
`ifdef BROM_COPIER_CHECKSUM_EN
  output logic [BUS_W-1:0]   o_checksum,
`endif
  output logic               o_dst_request,
  output logic               o_dst_rw,
  output logic [BUS_W-1:0]   o_dst_address,
  output logic [BUS_W-1:0]   o_dst_wdata,
  input  logic               i_dst_ready
);

  state_t               state_q, state_d;
  logic [COUNT_W-1:0]   count_q, count_d;
  logic [COUNT_W-1:0]   index_q, index_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 src_req_q, src_req_d;
  logic [BUS_W-1:0]     src_addr_q, src_addr_d;
  logic                 dst_req_q, dst_req_d;
  logic                 dst_rw_q, dst_rw_d;
  logic [BUS_W-1:0]     dst_addr_q, dst_addr_d;
  logic [BUS_W-1:0]     dst_wdata_q, dst_wdata_d;
`ifdef BROM_COPIER_CHECKSUM_EN
  logic [BUS_W-1:0]     csum_q, csum_d;
`endif

  // Index of the final word; only meaningful once a nonzero count is latched.
  logic                 last_word;
  assign last_word = (index_q == count_q - COUNT_W'(1));

  // State and registered-output register.
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      state_q     <= IDLE;
      count_q     <= '0;
      index_q     <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      src_req_q   <= 1'b0;
      src_addr_q  <= '0;
      dst_req_q   <= 1'b0;
      dst_rw_q    <= 1'b0;
      dst_addr_q  <= '0;
      dst_wdata_q <= '0;
`ifdef BROM_COPIER_CHECKSUM_EN
      csum_q      <= '0;
`endif
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      index_q     <= index_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      src_req_q   <= src_req_d;
      src_addr_q  <= src_addr_d;
      dst_req_q   <= dst_req_d;
      dst_rw_q    <= dst_rw_d;
      dst_addr_q  <= dst_addr_d;
      dst_wdata_q <= dst_wdata_d;
`ifdef BROM_COPIER_CHECKSUM_EN
      csum_q      <= csum_d;
`endif
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    index_d     = index_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    src_req_d   = src_req_q;
    src_addr_d  = src_addr_q;
    dst_req_d   = dst_req_q;
    dst_rw_d    = dst_rw_q;
    dst_addr_d  = dst_addr_q;
    dst_wdata_d = dst_wdata_q;
`ifdef BROM_COPIER_CHECKSUM_EN
    csum_d      = csum_q;
`endif

    unique case (state_q)
      IDLE: begin
        if (i_start) begin
`ifdef BROM_COPIER_CHECKSUM_EN
          csum_d = '0;
`endif
          if (i_count != '0) begin
            count_d    = i_count;
            index_d    = '0;
            src_addr_d = SRC_BASE;
            src_req_d  = 1'b1;
            busy_d     = 1'b1;
            state_d    = READ;
          end else begin
            // Empty copy completes at once without ever going busy.
            done_d = 1'b1;
          end
        end
      end

      READ: begin
        if (i_src_ready) begin
          src_req_d   = 1'b0;
          dst_wdata_d = i_src_rdata;
          dst_addr_d  = word_addr(DST_BASE, BUS_W'(index_q));
          dst_req_d   = 1'b1;
          dst_rw_d    = 1'b1;
`ifdef BROM_COPIER_CHECKSUM_EN
          csum_d      = csum_q + i_src_rdata;
`endif
          state_d     = WRITE;
        end
      end

      WRITE: begin
        if (i_dst_ready) begin
          dst_req_d = 1'b0;
          dst_rw_d  = 1'b0;
          if (last_word) begin
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = DONE;
          end else begin
            index_d    = index_q + COUNT_W'(1);
            src_addr_d = word_addr(SRC_BASE, BUS_W'(index_q) + BUS_W'(1));
            src_req_d  = 1'b1;
            state_d    = READ;
          end
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign o_busy        = busy_q;
  assign o_done        = done_q;
  assign o_src_request = src_req_q;
  assign o_src_address = src_addr_q;
  assign o_dst_request = dst_req_q;
  assign o_dst_rw      = dst_rw_q;
  assign o_dst_address = dst_addr_q;
  assign o_dst_wdata   = dst_wdata_q;
`ifdef BROM_COPIER_CHECKSUM_EN
  assign o_checksum    = csum_q;
`endif

endmodule

// File: tb/tb_brom_copier.sv
// Directed bench for brom_copier: ROM/RAM responder models, write log, and a
// linear sequence of directed steps with hand-computed expectations.
module tb_brom_copier;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        start, start2;
  logic [15:0] count, count2;

  logic        busy, done, src_req, src_ready, dst_req, dst_rw, dst_ready;
  logic [31:0] src_addr, src_rdata, dst_addr, dst_wdata, csum;
  logic        busy2, done2, src_req2, src_ready2, dst_req2, dst_rw2, dst_ready2;
  logic [31:0] src_addr2, src_rdata2, dst_addr2, dst_wdata2, csum2;

  brom_copier #(.SRC_BASE(32'h0000_0000), .DST_BASE(32'h0000_1000), .COUNT_W(16)) u_dut (
    .i_clock(clk), .i_reset(rst), .i_start(start), .i_count(count),
    .o_busy(busy), .o_done(done),
    .o_src_request(src_req), .o_src_address(src_addr),
    .i_src_rdata(src_rdata), .i_src_ready(src_ready),
`ifdef BROM_COPIER_CHECKSUM_EN
    .o_checksum(csum),
`endif
    .o_dst_request(dst_req), .o_dst_rw(dst_rw), .o_dst_address(dst_addr),
    .o_dst_wdata(dst_wdata), .i_dst_ready(dst_ready)
  );

  brom_copier #(.SRC_BASE(32'h0000_0000), .DST_BASE(32'hFFFF_FFFC), .COUNT_W(16)) u_wrap (
    .i_clock(clk), .i_reset(rst), .i_start(start2), .i_count(count2),
    .o_busy(busy2), .o_done(done2),
    .o_src_request(src_req2), .o_src_address(src_addr2),
    .i_src_rdata(src_rdata2), .i_src_ready(src_ready2),
`ifdef BROM_COPIER_CHECKSUM_EN
    .o_checksum(csum2),
`endif
    .o_dst_request(dst_req2), .o_dst_rw(dst_rw2), .o_dst_address(dst_addr2),
    .o_dst_wdata(dst_wdata2), .i_dst_ready(dst_ready2)
  );

`ifndef BROM_COPIER_CHECKSUM_EN
  assign csum  = 32'h0;
  assign csum2 = 32'h0;
`endif

  // ROM contents shared by both copiers.
  logic [31:0] rom [8];
  initial begin
    rom[0] = 32'h1111_1111; rom[1] = 32'h2222_2222;
    rom[2] = 32'h3333_3333; rom[3] = 32'h4444_4444;
    rom[4] = 32'h5555_5555; rom[5] = 32'h6666_6666;
    rom[6] = 32'h7777_7777; rom[7] = 32'h8888_8888;
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ROM responders: data and ready one cycle after a request.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      src_ready <= 1'b0; src_rdata <= '0; src_ready2 <= 1'b0; src_rdata2 <= '0;
    end else begin
      src_ready  <= src_req && !src_ready;
      src_rdata  <= rom[src_addr[4:2]];
      src_ready2 <= src_req2 && !src_ready2;
      src_rdata2 <= rom[src_addr2[4:2]];
    end
  end

  // RAM responders: ready after 1 cycle, or 5 cycles for slow_addr.
  logic [31:0] slow_addr;
  int          ram_wait;
  int          ram_dly;
  assign ram_dly = (dst_addr == slow_addr) ? 5 : 1;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      ram_wait <= 0; dst_ready <= 1'b0; dst_ready2 <= 1'b0;
    end else begin
      if (dst_req && !dst_ready) begin
        ram_wait  <= ram_wait + 1;
        dst_ready <= (ram_wait + 1 >= ram_dly);
      end else begin
        ram_wait  <= 0;
        dst_ready <= 1'b0;
      end
      dst_ready2 <= dst_req2 && !dst_ready2;
    end
  end

  // Bus monitors, sampled mid-cycle.
  logic [31:0] wr_addr[$], wr_data[$], wr2_addr[$], wr2_data[$];
  int done_cnt = 0, done2_cnt = 0, done_cyc = 0;
  int busy_seen = 0, req_seen = 0, overlap = 0, unstable = 0, rw_bad = 0, slow_cycles = 0;
  logic        prev_req = 1'b0;
  logic [31:0] prev_addr = '0, prev_data = '0;
  always @(negedge clk) begin
    if (dst_req && dst_ready) begin
      wr_addr.push_back(dst_addr); wr_data.push_back(dst_wdata);
    end
    if (dst_req2 && dst_ready2) begin
      wr2_addr.push_back(dst_addr2); wr2_data.push_back(dst_wdata2);
    end
    if (done)  begin done_cnt++; done_cyc = cyc; end
    if (done2) done2_cnt++;
    if (busy) busy_seen++;
    if (src_req || dst_req) req_seen++;
    if (src_req && dst_req) overlap++;
    if (dst_req && !dst_rw) rw_bad++;
    if (dst_req && dst_addr == slow_addr) slow_cycles++;
    if (dst_req && prev_req && (dst_addr != prev_addr || dst_wdata != prev_data)) unstable++;
    prev_req = dst_req; prev_addr = dst_addr; prev_data = dst_wdata;
  end

  int checks = 0, passes = 0;

  task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic do_start(input logic [15:0] c);
    @(negedge clk); start = 1'b1; count = c;
    @(negedge clk); start = 1'b0;
  endtask

  // Bounded wait for the next done pulse of the main copier.
  task automatic wait_done(input string tag, input int max_cyc);
    int base;
    base = done_cnt;
    for (int i = 0; i < max_cyc; i++) begin
      @(negedge clk); #1;
      if (done_cnt != base) break;
    end
    check32(tag, done_cnt - base, 1);
  endtask

  // Bounded wait for a condition on the main copier's ROM/RAM requests.
  task automatic wait_req(input string tag, input bit want_src, input logic [31:0] addr);
    bit hit;
    hit = 1'b0;
    for (int i = 0; i < 100 && !hit; i++) begin
      @(negedge clk); #1;
      hit = want_src ? (src_req && src_addr == addr) : dst_req;
    end
    check32(tag, 32'(hit), 1);
  endtask

  int t0, n0, p0;

  initial begin
    rst = 1'b1; start = 1'b0; start2 = 1'b0; count = '0; count2 = '0;
    slow_addr = 32'h1;

    // Reset values.
    #1;
    check32("rst_busy", 32'(busy), 0);
    check32("rst_done", 32'(done), 0);
    check32("rst_reqs", {30'b0, src_req, dst_req}, 0);
    check32("rst_rw", 32'(dst_rw), 0);
    check32("rst_src_addr", src_addr, 0);
    check32("rst_dst_addr", dst_addr, 0);
    check32("rst_wdata", dst_wdata, 0);
    @(negedge clk); @(negedge clk); rst = 1'b0;

    // Four-word copy into 0x1000.
    wr_addr.delete(); wr_data.delete(); n0 = done_cnt;
    do_start(16'd4); t0 = cyc;
    wait_done("t1_done", 100);
    repeat (5) @(negedge clk);
    #1;
    check32("t1_done_once", done_cnt - n0, 1);
    check32("t1_nwrites", wr_addr.size(), 4);
    if (wr_addr.size() == 4) begin
      check32("t1_addr0", wr_addr[0], 32'h1000); check32("t1_data0", wr_data[0], 32'h1111_1111);
      check32("t1_addr1", wr_addr[1], 32'h1004); check32("t1_data1", wr_data[1], 32'h2222_2222);
      check32("t1_addr2", wr_addr[2], 32'h1008); check32("t1_data2", wr_data[2], 32'h3333_3333);
      check32("t1_addr3", wr_addr[3], 32'h100C); check32("t1_data3", wr_data[3], 32'h4444_4444);
    end
    check32("t1_time", 32'((done_cyc - t0) >= 15 && (done_cyc - t0) <= 17), 1);
    check32("t1_busy_after", 32'(busy), 0);
`ifdef BROM_COPIER_CHECKSUM_EN
    check32("t1_checksum", csum, 32'hAAAA_AAAA);
`endif

    // Zero-word start: immediate done, never busy, no traffic.
    busy_seen = 0; req_seen = 0; n0 = done_cnt;
    do_start(16'd0);
    check32("t2_done_next", 32'(done), 1);
    repeat (4) @(negedge clk);
    #1;
    check32("t2_done_once", done_cnt - n0, 1);
    check32("t2_no_busy", busy_seen, 0);
    check32("t2_no_reqs", req_seen, 0);

    // Slow RAM on word 2: write held stable, no ROM read overlap.
    wr_addr.delete(); wr_data.delete();
    slow_addr = 32'h1004; slow_cycles = 0; unstable = 0; overlap = 0;
    do_start(16'd4); t0 = cyc;
    wait_done("t3_done", 200);
    check32("t3_nwrites", wr_addr.size(), 4);
    if (wr_addr.size() == 4) check32("t3_data1", wr_data[1], 32'h2222_2222);
    check32("t3_slow_cycles", slow_cycles, 6);
    check32("t3_stable", unstable, 0);
    check32("t3_no_overlap", overlap, 0);
    check32("t3_time", done_cyc - t0, 20);
    slow_addr = 32'h1;

    // Start strobe during the first write is ignored.
    wr_addr.delete(); wr_data.delete(); n0 = done_cnt;
    do_start(16'd3);
    wait_req("t4_see_write", 1'b0, 32'h0);
    start = 1'b1; count = 16'd7;
    @(negedge clk); start = 1'b0;
    wait_done("t4_done", 200);
    repeat (10) @(negedge clk);
    #1;
    check32("t4_nwrites", wr_addr.size(), 3);
    check32("t4_done_once", done_cnt - n0, 1);
    check32("t4_idle", {30'b0, busy, src_req}, 0);

    // Asynchronous reset during the second read, then a clean one-word copy.
    do_start(16'd4);
    wait_req("t5_see_read2", 1'b1, 32'h4);
    #2 rst = 1'b1;
    #1;
    check32("t5_reqs_drop", {30'b0, src_req, dst_req}, 0);
    check32("t5_busy_drop", 32'(busy), 0);
    @(negedge clk); rst = 1'b0;
    wr_addr.delete(); wr_data.delete();
    do_start(16'd1);
    wait_done("t5_done", 100);
    check32("t5_nwrites", wr_addr.size(), 1);
    if (wr_addr.size() == 1) begin
      check32("t5_addr", wr_addr[0], 32'h1000);
      check32("t5_data", wr_data[0], 32'h1111_1111);
    end

    // Destination address wrap-around on the second copier.
    wr2_addr.delete(); wr2_data.delete(); p0 = done2_cnt;
    @(negedge clk); start2 = 1'b1; count2 = 16'd2;
    @(negedge clk); start2 = 1'b0;
    for (int i = 0; i < 100 && done2_cnt == p0; i++) begin
      @(negedge clk); #1;
    end
    check32("t6_done", done2_cnt - p0, 1);
    check32("t6_nwrites", wr2_addr.size(), 2);
    if (wr2_addr.size() == 2) begin
      check32("t6_addr0", wr2_addr[0], 32'hFFFF_FFFC);
      check32("t6_data0", wr2_data[0], 32'h1111_1111);
      check32("t6_addr1_wrap", wr2_addr[1], 32'h0000_0000);
      check32("t6_data1", wr2_data[1], 32'h2222_2222);
    end

    check32("rw_high_with_req", rw_bad, 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
